// File: rtl/serial_four_bit_subtractor_if.sv
// rtl/serial_four_bit_subtractor_if.sv - start/busy/done operand and result bundle for the serial subtractor
// The ovf signal exists only when SUB_OVERFLOW_EN is defined.
interface serial_four_bit_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bi;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bo;
`ifdef SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, A, B, Bi,
    input  busy, done, D, Bo
`ifdef SUB_OVERFLOW_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, A, B, Bi,
    output busy, done, D, Bo
`ifdef SUB_OVERFLOW_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_four_bit_subtractor.sv
// rtl/serial_four_bit_subtractor.sv - bit-serial A - B - Bi, one full-subtractor stage, WIDTH cycles per result
// Optional signed-overflow flag enabled by defining SUB_OVERFLOW_EN.
module serial_four_bit_subtractor #(
  parameter int WIDTH = 4
) (
  input logic                          clk,
  input logic                          rst,
  serial_four_bit_subtractor_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] dr_q, dr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             bo_q, bo_d;
`ifdef SUB_OVERFLOW_EN
  logic             amsb_q, amsb_d;
  logic             bmsb_q, bmsb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] diff_next;

  // Single full-subtractor stage on the operand LSBs.
  assign a_bit     = ra_q[0];
  assign b_bit     = rb_q[0];
  assign d_bit     = a_bit ^ b_bit ^ br_q;
  assign br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign diff_next = {d_bit, dr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    br_d    = br_q;
    dr_d    = dr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    bo_d    = bo_q;
`ifdef SUB_OVERFLOW_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          ra_d    = bus.A;
          rb_d    = bus.B;
          br_d    = bus.Bi;
          cnt_d   = '0;
          dr_d    = '0;
`ifdef SUB_OVERFLOW_EN
          amsb_d  = bus.A[WIDTH-1];
          bmsb_d  = bus.B[WIDTH-1];
`endif
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        br_d  = br_next;
        dr_d  = diff_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          dout_d  = diff_next;
          bo_d    = br_next;
`ifdef SUB_OVERFLOW_EN
          ovf_d   = (amsb_q != bmsb_q) & (d_bit != amsb_q);
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      br_q    <= 1'b0;
      dr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      bo_q    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      br_q    <= br_d;
      dr_q    <= dr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      bo_q    <= bo_d;
`ifdef SUB_OVERFLOW_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.D    = dout_q;
  assign bus.Bo   = bo_q;
`ifdef SUB_OVERFLOW_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule

// File: doc/serial_four_bit_subtractor.md
# serial_four_bit_subtractor

Bit-serial subtractor that computes A − B − Bi over WIDTH clock cycles using one full-subtractor stage, a bit counter and operand shift registers. It is the subtraction counterpart to the ripple-carry adder datapath. A start/busy/done handshake lets a controller issue operations and collect results without a wide combinational borrow chain. The result and borrow-out are registered and held until the next operation completes.

## Interface
- WIDTH, 4, operand and result width in bits; must be ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin; sampled on rising clk
- A  input  WIDTH  minuend; sampled when start is accepted
- B  input  WIDTH  subtrahend; sampled when start is accepted
- Bi  input  1  borrow-in; sampled when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when D/Bo are updated
- D  output  WIDTH  difference A − B − Bi, modulo 2^WIDTH
- Bo  output  1  borrow-out; 1 when A < B + Bi (unsigned)
- ovf  output  1  signed overflow; present only with SUB_OVERFLOW_EN

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE or DONE, start=1:
  - latch A→ra, B→rb, Bi→br
  - clear bit counter cnt and the internal difference register
  - go to SHIFT
- IDLE or DONE, start=0: DONE→IDLE, IDLE stays IDLE.
- SHIFT, each cycle, with a=ra[0] and b=rb[0]:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - shift ra and rb right by 1
  - shift d into the MSB of the internal difference register
  - cnt += 1
- SHIFT, on the cycle with cnt = WIDTH−1:
  - D ← final difference
  - Bo ← br_next
  - go to DONE
- start while in SHIFT is ignored: no queuing, operands unchanged.
- D and Bo change only on entry to DONE and otherwise hold their last value.
- busy = (state == SHIFT).
- done = (state == DONE).
- Reset, asynchronous and allowed at any time, including mid-operation:
  - state → IDLE; busy, done, D, Bo, ovf, cnt and internal registers → 0
  - no done pulse for an aborted operation

## Timing
- Start accepted at rising edge k.
- SHIFT occupies edges k+1 … k+WIDTH.
- DONE is entered at edge k+WIDTH; done is high from edge k+WIDTH to edge k+WIDTH+1.
- Latency is WIDTH cycles from the accepting edge to done; 4 cycles at the default WIDTH.
- Back-to-back: start held high during DONE is accepted at that edge, giving one result every WIDTH+1 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SUB_OVERFLOW_EN defined:
  - ovf port exists
  - on entry to DONE, ovf ← (A_msb ≠ B_msb) & (D_msb ≠ A_msb), using the latched operand MSBs
  - ovf is held with D and reset to 0
- SUB_OVERFLOW_EN undefined:
  - ovf port and logic are absent
  - all other behaviour is identical

## Test plan
- Reset released, no start → busy=0, done=0, D=0, Bo=0 indefinitely.
- A=9, B=3, Bi=0, start one cycle → busy for 4 cycles, then done pulse with D=6, Bo=0. Repeat with Bi=1 → D=5, Bo=0.
- A=3, B=9, Bi=0 → D=4'hA, Bo=1. A=0, B=0, Bi=1 → D=4'hF, Bo=1.
- Start with A=9, B=3; pulse start with A=1, B=1 during SHIFT → result still D=6. Hold start through DONE with A=5, B=5 → second done exactly 5 cycles after the first with D=0, Bo=0.
- Start A=9, B=3, assert rst two cycles later → all outputs 0 immediately and no done. Then start A=2, B=1 → D=1, Bo=0.
- SUB_OVERFLOW_EN defined:
  - A=4'h7, B=4'hF → D=4'h8, Bo=1, ovf=1
  - A=4'h2, B=4'h1 → D=1, ovf=0
